// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern MSB-first onto x, repeated N times,
// with optional gap filler or overlapped repetitions; expected_z marks each final bit.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | x carries pattern[idx]
// GAP   | x carries gap_bit, gap counter counts down to 1
// DONE  | one-cycle done pulse, then back to IDLE
module sequence_generator #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             gap_bit,
    input  logic             overlap,
    output logic             x,
    output logic             x_valid,
    output logic             expected_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             gap_bit_q, gap_bit_d;
    logic             ovl_q, ovl_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             expected_z_q, expected_z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] sent_inc;
    logic [IDX_W-1:0] idx_dec;
    logic [IDX_W-1:0] idx_rel;

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_cnt_d    = gap_cnt_q;
        sent_cnt_d   = sent_cnt_q;
        rep_d        = rep_q;
        pat_d        = pat_q;
        gap_len_d    = gap_len_q;
        gap_bit_d    = gap_bit_q;
        ovl_d        = ovl_q;
        x_d          = 1'b0;
        x_valid_d    = 1'b0;
        expected_z_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        sent_inc = sent_cnt_q + CNT_W'(1);
        idx_dec  = idx_q - IDX_W'(1);
        idx_rel  = ovl_q ? IDX_W'(PAT_W - 2) : IDX_W'(PAT_W - 1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    sent_cnt_d = '0;
                    if (repeat_cnt == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        pat_d     = pattern;
                        rep_d     = repeat_cnt;
                        gap_len_d = gap_len;
                        gap_bit_d = gap_bit;
                        ovl_d     = overlap && (gap_len == '0) &&
                                    (pattern[PAT_W-1] == pattern[0]);
                        idx_d     = IDX_W'(PAT_W - 1);
                        state_d   = SEND;
                        x_d       = pattern[PAT_W-1];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            SEND: begin
                if (idx_q != '0) begin
                    idx_d        = idx_dec;
                    x_d          = pat_q[idx_dec];
                    x_valid_d    = 1'b1;
                    busy_d       = 1'b1;
                    expected_z_d = (idx_dec == '0);
                end else begin
                    sent_cnt_d = sent_inc;
                    if (sent_inc == rep_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_len_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q;
                        x_d       = gap_bit_q;
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        // Overlap reuses the last bit as the next repetition's first bit.
                        idx_d        = idx_rel;
                        x_d          = pat_q[idx_rel];
                        x_valid_d    = 1'b1;
                        busy_d       = 1'b1;
                        expected_z_d = (idx_rel == '0);
                    end
                end
            end
            GAP: begin
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                    idx_d   = IDX_W'(PAT_W - 1);
                    x_d     = pat_q[PAT_W-1];
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    x_d       = gap_bit_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            sent_cnt_q   <= '0;
            rep_q        <= '0;
            pat_q        <= '0;
            gap_len_q    <= '0;
            gap_bit_q    <= 1'b0;
            ovl_q        <= 1'b0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            expected_z_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            rep_q        <= rep_d;
            pat_q        <= pat_d;
            gap_len_q    <= gap_len_d;
            gap_bit_q    <= gap_bit_d;
            ovl_q        <= ovl_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            expected_z_q <= expected_z_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign expected_z = expected_z_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_cnt   = sent_cnt_q;

endmodule
